// File: rtl/fma_arb_pkg.sv
// Shared types for the FMA issue arbiter: request payload and tracker entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fma_arb_pkg;

  localparam int FLEN_REC  = 65;  // recoded FP operand width
  localparam int EXC_W     = 5;   // IEEE exception flag width
  // Packed types cannot follow per-instance parameters, so tags and ids are
  // carried at their largest supported width and narrowed at the ports.
  localparam int TAG_W_MAX = 16;
  localparam int ID_W_MAX  = 2;   // up to 4 requesters

  typedef struct packed {
    logic [2:0]          rm;
    logic [1:0]          fma_cmd;
    logic                ren3;
    logic                swap23;
    logic [FLEN_REC-1:0] in1;
    logic [FLEN_REC-1:0] in2;
    logic [FLEN_REC-1:0] in3;
    logic [TAG_W_MAX-1:0] tag;
  } fma_req_t;

  typedef struct packed {
    logic                 issued;
    logic                 killed;
    logic [ID_W_MAX-1:0]  id;
    logic [TAG_W_MAX-1:0] tag;
  } fma_trk_t;

endpackage

// File: rtl/fma_issue_arbiter_rr_arbiter.sv
// N-way round-robin grant; the pointer moves past the winner when the grant is used.
// Latency: grant is combinational from req_i; pointer updates on the clock edge.
// Backpressure: pointer holds unless advance_i reports the grant was taken.
// Ports: clock/reset, req_i (request vector), advance_i (grant consumed),
//        grant_o (one-hot grant), grant_id_o (index of the grant).
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] grant_id_o
);

  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] rr_d;
  logic            found;
  int              idx;

  // Search upward from the pointer, wrapping, and take the first requester.
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(rr_q) + off) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o = ID_W'(idx);
      end
    end
  end

  assign rr_d = advance_i ? ID_W'((int'(grant_id_o) + 1) % N) : rr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/fma_issue_arbiter.sv
// Shares one fixed-latency FMA pipe between N_REQ requesters and steers results back.
// Latency: issue is combinational (0 cycles); results return PIPE_LAT cycles after issue.
// Backpressure: one op per cycle via req_ready; flush/reset block issue; responses have none.
// Ports: clock/reset; req_* per-requester op bundles (flattened, requester i at slice i);
//        flush squashes in-flight ops; pipe_in_* drive the pipe; pipe_out_* come back;
//        resp_* return results one-hot by owner; busy and sticky err report tracker state.
module fma_issue_arbiter
  import fma_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int TAG_W    = 6,
  parameter int PIPE_LAT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_rm,
  input  logic [2*N_REQ-1:0]     req_fma_cmd,
  input  logic [N_REQ-1:0]       req_ren3,
  input  logic [N_REQ-1:0]       req_swap23,
  input  logic [65*N_REQ-1:0]    req_in1,
  input  logic [65*N_REQ-1:0]    req_in2,
  input  logic [65*N_REQ-1:0]    req_in3,
  input  logic [TAG_W*N_REQ-1:0] req_tag,
  input  logic                   flush,
  output logic                   pipe_in_valid,
  output logic [2:0]             pipe_in_rm,
  output logic [1:0]             pipe_in_fma_cmd,
  output logic                   pipe_in_ren3,
  output logic                   pipe_in_swap23,
  output logic [64:0]            pipe_in_in1,
  output logic [64:0]            pipe_in_in2,
  output logic [64:0]            pipe_in_in3,
  input  logic                   pipe_out_valid,
  input  logic [64:0]            pipe_out_data,
  input  logic [4:0]             pipe_out_exc,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [64:0]            resp_data,
  output logic [4:0]             resp_exc,
  output logic [TAG_W-1:0]       resp_tag,
  output logic                   busy,
  output logic                   err
);

  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W = $clog2(PIPE_LAT + 1);

  fma_req_t        req [N_REQ];
  fma_req_t        sel;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic            fire;

  fma_trk_t        trk_q [PIPE_LAT];
  fma_trk_t        trk_d [PIPE_LAT];
  fma_trk_t        last;
  logic            err_q, err_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req[i].rm      = req_rm[3*i +: 3];
      req[i].fma_cmd = req_fma_cmd[2*i +: 2];
      req[i].ren3    = req_ren3[i];
      req[i].swap23  = req_swap23[i];
      req[i].in1     = req_in1[FLEN_REC*i +: FLEN_REC];
      req[i].in2     = req_in2[FLEN_REC*i +: FLEN_REC];
      req[i].in3     = req_in3[FLEN_REC*i +: FLEN_REC];
      req[i].tag     = TAG_W_MAX'(req_tag[TAG_W*i +: TAG_W]);
    end
  end

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .clock      (clock),
    .reset      (reset),
    .req_i      (req_valid),
    .advance_i  (fire),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign req_ready = grant & {N_REQ{~flush & ~reset}};
  assign fire      = |req_ready;

  // Payload is only meaningful when pipe_in_valid is high.
  assign sel             = req[grant_id];
  assign pipe_in_valid   = fire;
  assign pipe_in_rm      = sel.rm;
  assign pipe_in_fma_cmd = sel.fma_cmd;
  assign pipe_in_ren3    = sel.ren3;
  assign pipe_in_swap23  = sel.swap23;
  assign pipe_in_in1     = sel.in1;
  assign pipe_in_in2     = sel.in2;
  assign pipe_in_in3     = sel.in3;

  // Tracker mirrors the pipe: the last stage lines up with pipe_out_valid.
  // A flush marks everything shifting this cycle as killed; nothing new can
  // enter in that cycle because ready is forced low.
  always_comb begin
    trk_d[0].issued = fire;
    trk_d[0].killed = 1'b0;
    trk_d[0].id     = ID_W_MAX'(grant_id);
    trk_d[0].tag    = sel.tag;
    for (int k = 1; k < PIPE_LAT; k++) begin
      trk_d[k]        = trk_q[k-1];
      trk_d[k].killed = trk_q[k-1].killed | flush;
    end
  end

  assign last = trk_q[PIPE_LAT-1];

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      resp_valid[i] = pipe_out_valid & last.issued & ~last.killed & ~flush & ~reset &
                      (last.id == ID_W_MAX'(i));
    end
  end

  assign resp_data = pipe_out_data;
  assign resp_exc  = pipe_out_exc;
  assign resp_tag  = TAG_W'(last.tag);

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < PIPE_LAT; k++) begin
      busy = busy | (trk_q[k].issued & ~trk_q[k].killed);
    end
    busy = busy & ~reset;
  end

  // Results of ops issued before reset can still leave the pipe for PIPE_LAT
  // cycles; the holdoff keeps them from tripping the alignment check.
  assign err_d  = err_q | ((hold_q == '0) & (pipe_out_valid != last.issued));
  assign hold_d = (hold_q == '0) ? hold_q : hold_q - HOLD_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        trk_q[k] <= '0;
      end
      err_q  <= 1'b0;
      hold_q <= HOLD_W'(PIPE_LAT);
    end else begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        trk_q[k] <= trk_d[k];
      end
      err_q  <= err_d;
      hold_q <= hold_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_fma_issue_arbiter.sv
// Self-checking bench for fma_issue_arbiter with a behavioural fixed-latency pipe.
// Latency: expected results are queued at issue and compared PIPE_LAT cycles later.
// Backpressure: none modelled beyond the arbiter's own req_ready.
module tb_fma_issue_arbiter;

  localparam int N   = 2;
  localparam int TW  = 6;
  localparam int LAT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [3*N-1:0]    req_rm;
  logic [2*N-1:0]    req_fma_cmd;
  logic [N-1:0]      req_ren3;
  logic [N-1:0]      req_swap23;
  logic [65*N-1:0]   req_in1;
  logic [65*N-1:0]   req_in2;
  logic [65*N-1:0]   req_in3;
  logic [TW*N-1:0]   req_tag;
  logic              flush;
  logic              pipe_in_valid;
  logic [2:0]        pipe_in_rm;
  logic [1:0]        pipe_in_fma_cmd;
  logic              pipe_in_ren3;
  logic              pipe_in_swap23;
  logic [64:0]       pipe_in_in1;
  logic [64:0]       pipe_in_in2;
  logic [64:0]       pipe_in_in3;
  logic              pipe_out_valid;
  logic [64:0]       pipe_out_data;
  logic [4:0]        pipe_out_exc;
  logic [N-1:0]      resp_valid;
  logic [64:0]       resp_data;
  logic [4:0]        resp_exc;
  logic [TW-1:0]     resp_tag;
  logic              busy;
  logic              err;

  always #5 clock = ~clock;

  fma_issue_arbiter #(
    .N_REQ    (N),
    .TAG_W    (TW),
    .PIPE_LAT (LAT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_rm          (req_rm),
    .req_fma_cmd     (req_fma_cmd),
    .req_ren3        (req_ren3),
    .req_swap23      (req_swap23),
    .req_in1         (req_in1),
    .req_in2         (req_in2),
    .req_in3         (req_in3),
    .req_tag         (req_tag),
    .flush           (flush),
    .pipe_in_valid   (pipe_in_valid),
    .pipe_in_rm      (pipe_in_rm),
    .pipe_in_fma_cmd (pipe_in_fma_cmd),
    .pipe_in_ren3    (pipe_in_ren3),
    .pipe_in_swap23  (pipe_in_swap23),
    .pipe_in_in1     (pipe_in_in1),
    .pipe_in_in2     (pipe_in_in2),
    .pipe_in_in3     (pipe_in_in3),
    .pipe_out_valid  (pipe_out_valid),
    .pipe_out_data   (pipe_out_data),
    .pipe_out_exc    (pipe_out_exc),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_exc        (resp_exc),
    .resp_tag        (resp_tag),
    .busy            (busy),
    .err             (err)
  );

  typedef struct {
    logic [N-1:0]  oh;
    logic [TW-1:0] tag;
    logic [64:0]   data;
    logic [4:0]    exc;
    int            due;
  } exp_t;

  exp_t sb[$];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int exp_rr  = 0;
  logic exp_err = 1'b0;

  // Per-requester payload driven this cycle
  logic [2:0]    d_rm  [N];
  logic [1:0]    d_cmd [N];
  logic          d_ren3[N];
  logic          d_sw  [N];
  logic [64:0]   d_in1 [N];
  logic [64:0]   d_in2 [N];
  logic [64:0]   d_in3 [N];
  logic [TW-1:0] d_tag [N];

  // Behavioural pipe: data = in1^in2, exc = in3[4:0]^{rm,cmd}
  logic        pv[LAT];
  logic [64:0] pd[LAT];
  logic [4:0]  pe[LAT];

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, obs, want);
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic fl, input logic rs, input logic inj);
    logic [N-1:0] rdy_w;
    logic         fire_w;
    int           g;
    int           idx;
    exp_t         e;
    logic         cap_v;
    logic [64:0]  cap_d;
    logic [4:0]   cap_e;

    for (int i = 0; i < N; i++) begin
      d_rm[i]   = 3'($urandom);
      d_cmd[i]  = 2'($urandom);
      d_ren3[i] = 1'($urandom);
      d_sw[i]   = 1'($urandom);
      d_in1[i]  = 65'({$urandom, $urandom, $urandom});
      d_in2[i]  = 65'({$urandom, $urandom, $urandom});
      d_in3[i]  = 65'({$urandom, $urandom, $urandom});
      d_tag[i]  = TW'($urandom);
      req_rm[3*i +: 3]      = d_rm[i];
      req_fma_cmd[2*i +: 2] = d_cmd[i];
      req_ren3[i]           = d_ren3[i];
      req_swap23[i]         = d_sw[i];
      req_in1[65*i +: 65]   = d_in1[i];
      req_in2[65*i +: 65]   = d_in2[i];
      req_in3[65*i +: 65]   = d_in3[i];
      req_tag[TW*i +: TW]   = d_tag[i];
    end
    req_valid      = v;
    flush          = fl;
    reset          = rs;
    pipe_out_valid = pv[LAT-1] | inj;
    pipe_out_data  = pd[LAT-1];
    pipe_out_exc   = pe[LAT-1];
    #4;

    // Expected round-robin winner
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (exp_rr + k) % N;
      if (g < 0 && v[idx]) g = idx;
    end
    rdy_w  = '0;
    fire_w = 1'b0;
    if (g >= 0 && !fl && !rs) begin
      rdy_w[g] = 1'b1;
      fire_w   = 1'b1;
    end
    chk("ready", 256'(req_ready), 256'(rdy_w));
    chk("pin_vld", 256'(pipe_in_valid), 256'(fire_w));
    if (fire_w) begin
      chk("pin_fields",
          256'({pipe_in_rm, pipe_in_fma_cmd, pipe_in_ren3, pipe_in_swap23,
                pipe_in_in1, pipe_in_in2, pipe_in_in3}),
          256'({d_rm[g], d_cmd[g], d_ren3[g], d_sw[g], d_in1[g], d_in2[g], d_in3[g]}));
    end

    if (rs) sb.delete();
    chk("busy", 256'(busy), 256'(sb.size() != 0));

    if (!fl && sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("resp_vld", 256'(resp_valid), 256'(e.oh));
      chk("resp_tag", 256'(resp_tag), 256'(e.tag));
      chk("resp_data", 256'(resp_data), 256'(e.data));
      chk("resp_exc", 256'(resp_exc), 256'(e.exc));
    end else begin
      chk("resp_vld", 256'(resp_valid), 256'(0));
    end
    if (fl) sb.delete();

    if (fire_w) begin
      e.oh   = N'(1) << g;
      e.tag  = d_tag[g];
      e.data = d_in1[g] ^ d_in2[g];
      e.exc  = d_in3[g][4:0] ^ {d_rm[g], d_cmd[g]};
      e.due  = cyc + LAT;
      sb.push_back(e);
      exp_rr = (g + 1) % N;
    end
    if (rs) exp_rr = 0;

    if (!rs) chk("err", 256'(err), 256'(exp_err));
    if (rs) exp_err = 1'b0;
    else if (inj) exp_err = 1'b1;

    cap_v = pipe_in_valid;
    cap_d = pipe_in_in1 ^ pipe_in_in2;
    cap_e = pipe_in_in3[4:0] ^ {pipe_in_rm, pipe_in_fma_cmd};
    @(posedge clock);
    #1;
    for (int k = LAT - 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      pd[k] = pd[k-1];
      pe[k] = pe[k-1];
    end
    pv[0] = cap_v;
    pd[0] = cap_d;
    pe[0] = cap_e;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < LAT; k++) begin
      pv[k] = 1'b0;
      pd[k] = '0;
      pe[k] = '0;
    end

    // Reset
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Single op from requester 0
    cycle(2'b01, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Contention: both valid for 6 cycles
    for (int i = 0; i < 6; i++) cycle(2'b11, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Flush after three issues; requester still valid in flush cycle
    for (int i = 0; i < 3; i++) cycle(2'b01, 1'b0, 1'b0, 1'b0);
    cycle(2'b01, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Flush coinciding with the result of a requester-1 op
    cycle(2'b10, 1'b0, 1'b0, 1'b0);
    idle(3);
    cycle(2'b00, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Random traffic with occasional flushes
    for (int i = 0; i < 40; i++) begin
      cycle(2'($urandom), ($urandom_range(0, 7) == 0), 1'b0, 1'b0);
    end
    idle(LAT + 2);

    // Misalignment: spurious pipe_out_valid sets sticky err
    cycle(2'b00, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Reset mid-flight: late results ignored, err cleared, pointer back to 0
    cycle(2'b01, 1'b0, 1'b0, 1'b0);
    cycle(2'b01, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b1, 1'b0);
    cycle(2'b11, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b0, 1'b0);
    idle(8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
